// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared types and constants for the ram arbiter slice.
//   state_t : arbiter sequencer states (IDLE -> ACCESS -> DONE)
//   grant_t : which requester owns / last owned the ram
//   RW_READ / RW_WRITE : ram ReadWrite encoding
package ram_arbiter_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 16;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_FETCH = 1'b0,
      GRANT_MEM   = 1'b1
   } grant_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundles the fetch port, load/store port and ram-side signals of the arbiter.
//   slave  : arbiter view (requests and RamDataOut in; grants, dones, data, Ram* out)
//   master : requesters + ram view (the mirror image)
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

   logic                  FetchReq;
   logic [ADDR_WIDTH-1:0] FetchAddress;
   logic                  FetchGrant;
   logic                  FetchDone;
   logic [DATA_WIDTH-1:0] FetchData;

   logic                  MemReq;
   logic                  MemReadWrite;
   logic [ADDR_WIDTH-1:0] MemAddress;
   logic [DATA_WIDTH-1:0] MemDataIn;
   logic                  MemGrant;
   logic                  MemDone;
   logic [DATA_WIDTH-1:0] MemData;

   logic                  RamEnable;
   logic                  RamReadWrite;
   logic [ADDR_WIDTH-1:0] RamAddress;
   logic [DATA_WIDTH-1:0] RamDataIn;
   logic [DATA_WIDTH-1:0] RamDataOut;

   modport slave (
      input  FetchReq, FetchAddress,
      output FetchGrant, FetchDone, FetchData,
      input  MemReq, MemReadWrite, MemAddress, MemDataIn,
      output MemGrant, MemDone, MemData,
      output RamEnable, RamReadWrite, RamAddress, RamDataIn,
      input  RamDataOut
   );

   modport master (
      output FetchReq, FetchAddress,
      input  FetchGrant, FetchDone, FetchData,
      output MemReq, MemReadWrite, MemAddress, MemDataIn,
      input  MemGrant, MemDone, MemData,
      input  RamEnable, RamReadWrite, RamAddress, RamDataIn,
      output RamDataOut
   );

endinterface

// File: rtl/ram_arbiter_pick.sv
// rr_pick2
//   Combinational two-way round-robin picker.
//   i_req_fetch / i_req_mem : pending requests
//   i_last                  : requester granted most recently
//   o_valid                 : at least one request pending
//   o_winner                : requester to grant (on a tie, the one not in i_last)
module rr_pick2
   import ram_arbiter_pkg::*;
(
   input  logic   i_req_fetch,
   input  logic   i_req_mem,
   input  grant_t i_last,
   output logic   o_valid,
   output grant_t o_winner
);

   always_comb begin
      o_valid  = i_req_fetch | i_req_mem;
      o_winner = GRANT_FETCH;
      if (i_req_fetch && i_req_mem) begin
         o_winner = (i_last == GRANT_MEM) ? GRANT_FETCH : GRANT_MEM;
      end else if (i_req_mem) begin
         o_winner = GRANT_MEM;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares a single-port asynchronous ram between the fetch port (read only)
//   and the load/store port (read/write). Round-robin grant, request latched
//   at grant, Enable held ACCESS_CYCLES cycles, read data registered back to
//   the winner, one-cycle Done.
//   Clock  : rising-edge clock
//   ResetN : asynchronous active-low reset
//   arb    : ram_arbiter_if.slave (fetch port, load/store port, ram side)
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned ACCESS_CYCLES = 1
) (
   input  logic          Clock,
   input  logic          ResetN,
   ram_arbiter_if.slave  arb
);

   localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ACCESS_CYCLES - 1);

   state_t                r_state;
   logic [CNT_W-1:0]      r_count;
   grant_t                r_last;
   grant_t                r_owner;
   logic                  r_fetch_grant;
   logic                  r_fetch_done;
   logic [DATA_WIDTH-1:0] r_fetch_data;
   logic                  r_mem_grant;
   logic                  r_mem_done;
   logic [DATA_WIDTH-1:0] r_mem_data;
   logic                  r_ram_en;
   logic                  r_ram_rw;
   logic [ADDR_WIDTH-1:0] r_ram_addr;
   logic [DATA_WIDTH-1:0] r_ram_din;

   logic                  w_valid;
   grant_t                w_winner;

   rr_pick2 u_pick (
      .i_req_fetch (arb.FetchReq),
      .i_req_mem   (arb.MemReq),
      .i_last      (r_last),
      .o_valid     (w_valid),
      .o_winner    (w_winner)
   );

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_state       <= ST_IDLE;
         r_count       <= '0;
         r_last        <= GRANT_MEM;
         r_owner       <= GRANT_FETCH;
         r_fetch_grant <= 1'b0;
         r_fetch_done  <= 1'b0;
         r_fetch_data  <= '0;
         r_mem_grant   <= 1'b0;
         r_mem_done    <= 1'b0;
         r_mem_data    <= '0;
         r_ram_en      <= 1'b0;
         r_ram_rw      <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_din     <= '0;
      end else begin
         // Done flags are single-cycle pulses raised on the ACCESS->DONE edge.
         r_fetch_done <= 1'b0;
         r_mem_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_owner  <= w_winner;
                  r_last   <= w_winner;
                  r_count  <= '0;
                  r_ram_en <= 1'b1;
                  r_state  <= ST_ACCESS;
                  if (w_winner == GRANT_FETCH) begin
                     r_fetch_grant <= 1'b1;
                     r_ram_rw      <= RW_READ;
                     r_ram_addr    <= arb.FetchAddress;
                  end else begin
                     r_mem_grant <= 1'b1;
                     r_ram_rw    <= arb.MemReadWrite;
                     r_ram_addr  <= arb.MemAddress;
                     r_ram_din   <= arb.MemDataIn;
                  end
               end
            end
            ST_ACCESS: begin
               r_count <= r_count + 1'b1;
               if (r_count == LAST_COUNT) begin
                  r_ram_en <= 1'b0;
                  r_state  <= ST_DONE;
                  if (r_owner == GRANT_FETCH) begin
                     r_fetch_done <= 1'b1;
                     r_fetch_data <= arb.RamDataOut;
                  end else begin
                     r_mem_done <= 1'b1;
                     if (r_ram_rw == RW_READ) begin
                        r_mem_data <= arb.RamDataOut;
                     end
                  end
               end
            end
            ST_DONE: begin
               r_fetch_grant <= 1'b0;
               r_mem_grant   <= 1'b0;
               r_state       <= ST_IDLE;
            end
            default: begin
               r_fetch_grant <= 1'b0;
               r_mem_grant   <= 1'b0;
               r_ram_en      <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign arb.FetchGrant   = r_fetch_grant;
   assign arb.FetchDone    = r_fetch_done;
   assign arb.FetchData    = r_fetch_data;
   assign arb.MemGrant     = r_mem_grant;
   assign arb.MemDone      = r_mem_done;
   assign arb.MemData      = r_mem_data;
   assign arb.RamEnable    = r_ram_en;
   assign arb.RamReadWrite = r_ram_rw;
   assign arb.RamAddress   = r_ram_addr;
   assign arb.RamDataIn    = r_ram_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Drives ram_arbiter (ACCESS_CYCLES=3) with a behavioural ram attached,
//   compares every cycle against a transaction-level reference, and pins the
//   reference with hand-computed literal expectations.
module tb_ram_arbiter;

   localparam int AC = 3;

   logic Clock  = 1'b0;
   logic ResetN = 1'b0;
   int   cyc    = 0;
   int   checks   = 0;
   int   failures = 0;

   ram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

   ram_arbiter #(
      .ADDR_WIDTH    (16),
      .DATA_WIDTH    (32),
      .ACCESS_CYCLES (AC)
   ) dut (
      .Clock  (Clock),
      .ResetN (ResetN),
      .arb    (bus)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // ---------------- behavioural ram ----------------
   logic [31:0] ram [0:65535];
   always @(posedge Clock) begin
      if (bus.RamEnable && bus.RamReadWrite == 1'b0) ram[bus.RamAddress] <= bus.RamDataIn;
   end
   // Garbage when disabled so a capture outside the window is visible.
   assign bus.RamDataOut = bus.RamEnable ? ram[bus.RamAddress] : 32'hDEAD_BEEF;

   // ---------------- reference model ----------------
   // phase: 0 idle, 1..AC ram enabled, AC+1 done cycle
   int          m_phase    = 0;
   bit          m_mem_own  = 1'b0;
   bit          m_last_mem = 1'b1;
   logic        m_rw       = 1'b0;
   logic [15:0] m_addr     = '0;
   logic [31:0] m_din      = '0;
   logic [31:0] m_fdata    = '0;
   logic [31:0] m_mdata    = '0;
   logic [31:0] ref_mem [logic [15:0]];

   always @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         m_phase = 0; m_mem_own = 1'b0; m_last_mem = 1'b1;
         m_rw = 1'b0; m_addr = '0; m_din = '0; m_fdata = '0; m_mdata = '0;
      end else if (m_phase == 0) begin
         if (bus.FetchReq || bus.MemReq) begin
            m_mem_own  = bus.MemReq && (!bus.FetchReq || !m_last_mem);
            m_last_mem = m_mem_own;
            if (m_mem_own) begin
               m_rw = bus.MemReadWrite; m_addr = bus.MemAddress; m_din = bus.MemDataIn;
            end else begin
               m_rw = 1'b1; m_addr = bus.FetchAddress;
            end
            m_phase = 1;
         end
      end else if (m_phase <= AC) begin
         if (m_phase == AC) begin
            if (!m_rw) ref_mem[m_addr] = m_din;
            else if (m_mem_own) m_mdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 32'h0;
            else m_fdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 32'h0;
         end
         m_phase = m_phase + 1;
      end else begin
         m_phase = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge Clock) begin
      bit busy;
      busy = (m_phase != 0);
      check("FetchGrant",   32'(bus.FetchGrant),   32'(busy && !m_mem_own));
      check("MemGrant",     32'(bus.MemGrant),     32'(busy && m_mem_own));
      check("FetchDone",    32'(bus.FetchDone),    32'(m_phase == AC + 1 && !m_mem_own));
      check("MemDone",      32'(bus.MemDone),      32'(m_phase == AC + 1 && m_mem_own));
      check("RamEnable",    32'(bus.RamEnable),    32'(m_phase >= 1 && m_phase <= AC));
      check("RamReadWrite", 32'(bus.RamReadWrite), 32'(m_rw));
      check("RamAddress",   32'(bus.RamAddress),   32'(m_addr));
      check("RamDataIn",    bus.RamDataIn,         m_din);
      check("FetchData",    bus.FetchData,         m_fdata);
      check("MemData",      bus.MemData,           m_mdata);
      check("one_grant",    32'(bus.FetchGrant && bus.MemGrant), 32'h0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Fetch requester: holds Req until Done, scrambles address after grant,
   // drops Req the cycle after Done. lat = done cycle - grant cycle (-1 if none).
   task automatic do_fetch(input logic [15:0] a, output int lat, output int en_cnt);
      int g;
      g = -1; lat = -1; en_cnt = 0;
      bus.FetchReq = 1'b1; bus.FetchAddress = a;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (bus.RamEnable) en_cnt++;
         if (bus.FetchGrant && g < 0) begin g = cyc; bus.FetchAddress = ~a; end
         if (bus.FetchDone) begin lat = cyc - g; break; end
      end
      tick();
      check("fetch_done_width", 32'(bus.FetchDone), 32'h0);
      bus.FetchReq = 1'b0;
   endtask

   task automatic do_mem(input logic rw, input logic [15:0] a, input logic [31:0] d,
                         output int lat, output int en_cnt);
      int g;
      g = -1; lat = -1; en_cnt = 0;
      bus.MemReq = 1'b1; bus.MemReadWrite = rw; bus.MemAddress = a; bus.MemDataIn = d;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (bus.RamEnable) en_cnt++;
         if (bus.MemGrant && g < 0) begin
            g = cyc; bus.MemAddress = ~a; bus.MemDataIn = ~d; bus.MemReadWrite = ~rw;
         end
         if (bus.MemDone) begin lat = cyc - g; break; end
      end
      tick();
      check("mem_done_width", 32'(bus.MemDone), 32'h0);
      bus.MemReq = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40; n++) begin
         if (!bus.FetchGrant && !bus.MemGrant) break;
         tick();
      end
      check("idle_timeout", {30'h0, bus.FetchGrant, bus.MemGrant}, 32'h0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat, en;
      int order [$];
      bit pf, pm;

      bus.FetchReq = 1'b0; bus.FetchAddress = '0;
      bus.MemReq = 1'b0; bus.MemReadWrite = 1'b1; bus.MemAddress = '0; bus.MemDataIn = '0;

      // Reset held with both requests high: nothing may reach the ram.
      bus.FetchReq = 1'b1; bus.MemReq = 1'b1;
      repeat (4) tick();
      check("rst_enable", 32'(bus.RamEnable), 32'h0);
      check("rst_grants", {30'h0, bus.FetchGrant, bus.MemGrant}, 32'h0);
      check("rst_fdata", bus.FetchData, 32'h0);
      bus.FetchReq = 1'b0; bus.MemReq = 1'b0;
      tick();
      ResetN = 1'b1;
      tick();

      // Store then fetch the same word.
      do_mem(1'b0, 16'h0003, 32'h00CC_FFFF, lat, en);
      check("wr_latency", 32'(lat), 32'(AC));
      check("wr_enable_cycles", 32'(en), 32'(AC));
      do_fetch(16'h0003, lat, en);
      check("rd_latency", 32'(lat), 32'(AC));
      check("rd_enable_cycles", 32'(en), 32'(AC));
      check("rd_fetch_data", bus.FetchData, 32'h00CC_FFFF);

      // Fresh reset, then both requesters hold Req continuously.
      ResetN = 1'b0;
      repeat (2) tick();
      bus.FetchReq = 1'b1; bus.FetchAddress = 16'h0003;
      bus.MemReq = 1'b1; bus.MemReadWrite = 1'b0; bus.MemAddress = 16'h0020; bus.MemDataIn = 32'h1234_5678;
      ResetN = 1'b1;
      pf = 1'b0; pm = 1'b0;
      for (int n = 0; n < 22; n++) begin
         tick();
         if (bus.FetchGrant && !pf) order.push_back(0);
         if (bus.MemGrant && !pm) order.push_back(1);
         pf = bus.FetchGrant; pm = bus.MemGrant;
      end
      bus.FetchReq = 1'b0; bus.MemReq = 1'b0;
      wait_idle();
      check("rr_count_ge4", 32'(order.size() >= 4), 32'h1);
      while (order.size() < 4) order.push_back(-1);
      check("rr_grant0_F", 32'(order[0]), 32'h0);
      check("rr_grant1_M", 32'(order[1]), 32'h1);
      check("rr_grant2_F", 32'(order[2]), 32'h0);
      check("rr_grant3_M", 32'(order[3]), 32'h1);
      tick();

      // Reset in the 2nd ACCESS cycle: access abandoned, then re-served.
      bus.FetchReq = 1'b1; bus.FetchAddress = 16'h0003;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (bus.FetchGrant) break;
      end
      check("mid_grant_seen", 32'(bus.FetchGrant), 32'h1);
      tick();
      check("mid_enable_before", 32'(bus.RamEnable), 32'h1);
      #2 ResetN = 1'b0;
      #1;
      check("mid_enable_drop", 32'(bus.RamEnable), 32'h0);
      check("mid_grant_drop", 32'(bus.FetchGrant), 32'h0);
      tick();
      check("mid_no_done_a", 32'(bus.FetchDone), 32'h0);
      tick();
      check("mid_no_done_b", 32'(bus.FetchDone), 32'h0);
      ResetN = 1'b1;
      do_fetch(16'h0003, lat, en);
      check("mid_reserve_latency", 32'(lat), 32'(AC));
      check("mid_reserve_data", bus.FetchData, 32'h00CC_FFFF);

      // Top address: store, check MemData untouched by the write, load back.
      do_mem(1'b0, 16'hFFFF, 32'hFFFF_EFFF, lat, en);
      check("top_wr_latency", 32'(lat), 32'(AC));
      check("top_wr_memdata", bus.MemData, 32'h0);
      do_mem(1'b1, 16'hFFFF, 32'h0, lat, en);
      check("top_rd_latency", 32'(lat), 32'(AC));
      check("top_rd_memdata", bus.MemData, 32'hFFFF_EFFF);
      check("top_fetchdata_kept", bus.FetchData, 32'h00CC_FFFF);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
